// File: rtl/painterengine_gpu_clip_stream.sv
// Texture clip stage: align anchor, clip source to texture, clip destination to limit window (mirror-aware).
// Fixed 7-cycle accept-to-response latency; one request in flight; response held under backpressure. Stats: PAINTERENGINE_GPU_CLIP_STATS_EN.
module painterengine_gpu_clip_stream #(
  parameter int PARAM_COORD_WIDTH = 16,
  parameter int PARAM_STAT_WIDTH  = 16
) (
  input  logic                         i_wire_clock,
  input  logic                         i_wire_resetn,
  input  logic                         i_wire_req_valid,
  output logic                         o_wire_req_ready,
  input  logic [PARAM_COORD_WIDTH-1:0] i_wire_texture_width,
  input  logic [PARAM_COORD_WIDTH-1:0] i_wire_texture_height,
  input  logic [PARAM_COORD_WIDTH-1:0] i_wire_clip_x,
  input  logic [PARAM_COORD_WIDTH-1:0] i_wire_clip_y,
  input  logic [PARAM_COORD_WIDTH-1:0] i_wire_clip_width,
  input  logic [PARAM_COORD_WIDTH-1:0] i_wire_clip_height,
  input  logic [PARAM_COORD_WIDTH-1:0] i_wire_x,
  input  logic [PARAM_COORD_WIDTH-1:0] i_wire_y,
  input  logic [PARAM_COORD_WIDTH-1:0] i_wire_limit_left,
  input  logic [PARAM_COORD_WIDTH-1:0] i_wire_limit_top,
  input  logic [PARAM_COORD_WIDTH-1:0] i_wire_limit_right,
  input  logic [PARAM_COORD_WIDTH-1:0] i_wire_limit_bottom,
  input  logic [3:0]                   i_wire_texture_align,
  input  logic [2:0]                   i_wire_texture_mirror_mode,
  output logic                         o_wire_rsp_valid,
  input  logic                         i_wire_rsp_ready,
  output logic [PARAM_COORD_WIDTH-1:0] o_wire_x,
  output logic [PARAM_COORD_WIDTH-1:0] o_wire_y,
  output logic [PARAM_COORD_WIDTH-1:0] o_wire_clipx,
  output logic [PARAM_COORD_WIDTH-1:0] o_wire_clipy,
  output logic [PARAM_COORD_WIDTH-1:0] o_wire_clipw,
  output logic [PARAM_COORD_WIDTH-1:0] o_wire_cliph,
  output logic                         o_wire_reject,
`ifdef PAINTERENGINE_GPU_CLIP_STATS_EN
  input  logic                         i_wire_stat_clear,
  output logic [PARAM_STAT_WIDTH-1:0]  o_wire_stat_accepted,
  output logic [PARAM_STAT_WIDTH-1:0]  o_wire_stat_rejected,
`endif
  output logic                         o_wire_busy
);

  localparam int W  = PARAM_COORD_WIDTH;
  localparam int IW = PARAM_COORD_WIDTH + 2;

  typedef logic signed [IW-1:0] ival_t;

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_TEX_X, S_TEX_Y, S_TEX_WH, S_LIM_X, S_LIM_Y, S_RESP
  } state_t;

  function automatic ival_t sx(input logic [W-1:0] v);
    return {{2{v[W-1]}}, v};
  endfunction

  state_t        state_q;
  ival_t         x_q, y_q, cx_q, cy_q, cw_q, ch_q, tw_q, th_q;
  ival_t         lim_l_q, lim_t_q, lim_r_q, lim_b_q;
  logic [3:0]    align_q;
  logic [2:0]    mirror_q;
  logic          rej_q;
  logic          rsp_valid_q, out_rej_q;
  logic [W-1:0]  out_x_q, out_y_q, out_cx_q, out_cy_q, out_cw_q, out_ch_q;

  ival_t hw, hh, ax, ay;
  ival_t lx_raw, rx_raw, ly_raw, ry_raw, lx, rx, ly, ry, lrx, lry;
  logic  mir_h, mir_v, accept;

  assign accept = (state_q == S_IDLE) && i_wire_req_valid;
  assign mir_h  = mirror_q[0];
  assign mir_v  = mirror_q[1];

  assign hw = cw_q >>> 1;
  assign hh = ch_q >>> 1;

  // Numpad anchor: columns 1/4/7 left, 2/5/8 centre, 3/6/9 right; rows 7-9 top, 4-6 middle, 1-3 bottom.
  always_comb begin
    ax = x_q;
    ay = y_q;
    case (align_q)
      4'd8, 4'd5, 4'd2: ax = x_q - hw;
      4'd9, 4'd6, 4'd3: ax = x_q - cw_q;
      default:          ax = x_q;
    endcase
    case (align_q)
      4'd4, 4'd5, 4'd6: ay = y_q - hh;
      4'd1, 4'd2, 4'd3: ay = y_q - ch_q;
      default:          ay = y_q;
    endcase
  end

  // Pixels cut on the low (l) and high (r) side of the limit window.
  assign lx_raw = lim_l_q - x_q;
  assign rx_raw = x_q + cw_q - ival_t'(1) - lim_r_q;
  assign ly_raw = lim_t_q - y_q;
  assign ry_raw = y_q + ch_q - ival_t'(1) - lim_b_q;
  assign lx     = (lx_raw > ival_t'(0)) ? lx_raw : ival_t'(0);
  assign rx     = (rx_raw > ival_t'(0)) ? rx_raw : ival_t'(0);
  assign ly     = (ly_raw > ival_t'(0)) ? ly_raw : ival_t'(0);
  assign ry     = (ry_raw > ival_t'(0)) ? ry_raw : ival_t'(0);
  assign lrx    = lx + rx;
  assign lry    = ly + ry;

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      cw_q        <= '0;
      ch_q        <= '0;
      tw_q        <= '0;
      th_q        <= '0;
      lim_l_q     <= '0;
      lim_t_q     <= '0;
      lim_r_q     <= '0;
      lim_b_q     <= '0;
      align_q     <= '0;
      mirror_q    <= '0;
      rej_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      out_rej_q   <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_cx_q    <= '0;
      out_cy_q    <= '0;
      out_cw_q    <= '0;
      out_ch_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            tw_q     <= sx(i_wire_texture_width);
            th_q     <= sx(i_wire_texture_height);
            cx_q     <= sx(i_wire_clip_x);
            cy_q     <= sx(i_wire_clip_y);
            cw_q     <= sx(i_wire_clip_width);
            ch_q     <= sx(i_wire_clip_height);
            x_q      <= sx(i_wire_x);
            y_q      <= sx(i_wire_y);
            lim_l_q  <= sx(i_wire_limit_left);
            lim_t_q  <= sx(i_wire_limit_top);
            lim_r_q  <= sx(i_wire_limit_right);
            lim_b_q  <= sx(i_wire_limit_bottom);
            align_q  <= i_wire_texture_align;
            mirror_q <= i_wire_texture_mirror_mode;
            rej_q    <= 1'b0;
            state_q  <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (mirror_q[2]) begin
            rej_q <= 1'b1;
          end else begin
            x_q <= ax;
            y_q <= ay;
          end
          state_q <= S_TEX_X;
        end
        S_TEX_X: begin
          if (!rej_q) begin
            if (cx_q >= tw_q) begin
              rej_q <= 1'b1;
            end else if (cx_q < ival_t'(0)) begin
              x_q  <= x_q - cx_q;
              cw_q <= cw_q + cx_q;
              cx_q <= '0;
            end
          end
          state_q <= S_TEX_Y;
        end
        S_TEX_Y: begin
          if (!rej_q) begin
            if (cy_q >= th_q) begin
              rej_q <= 1'b1;
            end else if (cy_q < ival_t'(0)) begin
              y_q  <= y_q - cy_q;
              ch_q <= ch_q + cy_q;
              cy_q <= '0;
            end
          end
          state_q <= S_TEX_WH;
        end
        S_TEX_WH: begin
          if (!rej_q) begin
            if (cw_q <= ival_t'(0) || ch_q <= ival_t'(0)) begin
              rej_q <= 1'b1;
            end else begin
              if (cx_q + cw_q > tw_q) cw_q <= tw_q - cx_q;
              if (cy_q + ch_q > th_q) ch_q <= th_q - cy_q;
            end
          end
          state_q <= S_LIM_X;
        end
        S_LIM_X: begin
          if (!rej_q) begin
            if (lrx >= cw_q) begin
              rej_q <= 1'b1;
            end else begin
              cw_q <= cw_q - lrx;
              x_q  <= x_q + lx;
              cx_q <= cx_q + (mir_h ? rx : lx);
            end
          end
          state_q <= S_LIM_Y;
        end
        S_LIM_Y: begin
          if (!rej_q) begin
            if (lry >= ch_q) begin
              rej_q <= 1'b1;
            end else begin
              ch_q <= ch_q - lry;
              y_q  <= y_q + ly;
              cy_q <= cy_q + (mir_v ? ry : ly);
            end
          end
          state_q <= S_RESP;
        end
        S_RESP: begin
          // First RESP cycle loads the result registers; later cycles wait for the handshake.
          if (!rsp_valid_q) begin
            out_x_q     <= x_q[W-1:0];
            out_y_q     <= y_q[W-1:0];
            out_cx_q    <= cx_q[W-1:0];
            out_cy_q    <= cy_q[W-1:0];
            out_cw_q    <= rej_q ? '0 : cw_q[W-1:0];
            out_ch_q    <= rej_q ? '0 : ch_q[W-1:0];
            out_rej_q   <= rej_q;
            rsp_valid_q <= 1'b1;
          end else if (i_wire_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_wire_req_ready = (state_q == S_IDLE);
  assign o_wire_busy      = (state_q != S_IDLE);
  assign o_wire_rsp_valid = rsp_valid_q;
  assign o_wire_reject    = out_rej_q;
  assign o_wire_x         = out_x_q;
  assign o_wire_y         = out_y_q;
  assign o_wire_clipx     = out_cx_q;
  assign o_wire_clipy     = out_cy_q;
  assign o_wire_clipw     = out_cw_q;
  assign o_wire_cliph     = out_ch_q;

`ifdef PAINTERENGINE_GPU_CLIP_STATS_EN
  logic [PARAM_STAT_WIDTH-1:0] stat_acc_q, stat_acc_d, stat_rej_q, stat_rej_d;
  logic                        rej_fire;

  assign rej_fire = rsp_valid_q && i_wire_rsp_ready && out_rej_q;

  always_comb begin
    stat_acc_d = stat_acc_q;
    stat_rej_d = stat_rej_q;
    if (i_wire_stat_clear) begin
      stat_acc_d = '0;
      stat_rej_d = '0;
    end else begin
      if (accept && !(&stat_acc_q))   stat_acc_d = stat_acc_q + 1'b1;
      if (rej_fire && !(&stat_rej_q)) stat_rej_d = stat_rej_q + 1'b1;
    end
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      stat_acc_q <= '0;
      stat_rej_q <= '0;
    end else begin
      stat_acc_q <= stat_acc_d;
      stat_rej_q <= stat_rej_d;
    end
  end

  assign o_wire_stat_accepted = stat_acc_q;
  assign o_wire_stat_rejected = stat_rej_q;
`endif

endmodule

// File: tb/tb_painterengine_gpu_clip_stream.sv
// Bench for painterengine_gpu_clip_stream: directed cases plus randomized requests against an interval-based model.
module tb_painterengine_gpu_clip_stream;

  localparam int W = 16;

  typedef struct {
    int tw, th, cx, cy, cw, ch, x, y, l, t, r, b, al, mi;
  } req_t;

  typedef struct {
    logic [W-1:0] x, y, cx, cy, cw, ch;
    logic         rej;
  } res_t;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] tw = '0, th = '0, cx = '0, cy = '0, cw = '0, ch = '0, x = '0, y = '0;
  logic [W-1:0] lim_l = '0, lim_t = '0, lim_r = '0, lim_b = '0;
  logic [3:0]   align = '0;
  logic [2:0]   mirror = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] o_x, o_y, o_cx, o_cy, o_cw, o_ch;
  logic         o_rej, busy;
`ifdef PAINTERENGINE_GPU_CLIP_STATS_EN
  logic         stat_clear = 1'b0;
  logic [15:0]  stat_acc, stat_rej;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  painterengine_gpu_clip_stream #(.PARAM_COORD_WIDTH(W), .PARAM_STAT_WIDTH(16)) dut (
    .i_wire_clock               (clk),
    .i_wire_resetn              (resetn),
    .i_wire_req_valid           (req_valid),
    .o_wire_req_ready           (req_ready),
    .i_wire_texture_width       (tw),
    .i_wire_texture_height      (th),
    .i_wire_clip_x              (cx),
    .i_wire_clip_y              (cy),
    .i_wire_clip_width          (cw),
    .i_wire_clip_height         (ch),
    .i_wire_x                   (x),
    .i_wire_y                   (y),
    .i_wire_limit_left          (lim_l),
    .i_wire_limit_top           (lim_t),
    .i_wire_limit_right         (lim_r),
    .i_wire_limit_bottom        (lim_b),
    .i_wire_texture_align       (align),
    .i_wire_texture_mirror_mode (mirror),
    .o_wire_rsp_valid           (rsp_valid),
    .i_wire_rsp_ready           (rsp_ready),
    .o_wire_x                   (o_x),
    .o_wire_y                   (o_y),
    .o_wire_clipx               (o_cx),
    .o_wire_clipy               (o_cy),
    .o_wire_clipw               (o_cw),
    .o_wire_cliph               (o_ch),
    .o_wire_reject              (o_rej),
`ifdef PAINTERENGINE_GPU_CLIP_STATS_EN
    .i_wire_stat_clear          (stat_clear),
    .o_wire_stat_accepted       (stat_acc),
    .o_wire_stat_rejected       (stat_rej),
`endif
    .o_wire_busy                (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cmp_res(input string tag, input res_t g, input res_t e);
    check_eq($sformatf("%s.x", tag),   32'(g.x),   32'(e.x));
    check_eq($sformatf("%s.y", tag),   32'(g.y),   32'(e.y));
    check_eq($sformatf("%s.cx", tag),  32'(g.cx),  32'(e.cx));
    check_eq($sformatf("%s.cy", tag),  32'(g.cy),  32'(e.cy));
    check_eq($sformatf("%s.cw", tag),  32'(g.cw),  32'(e.cw));
    check_eq($sformatf("%s.ch", tag),  32'(g.ch),  32'(e.ch));
    check_eq($sformatf("%s.rej", tag), 32'(g.rej), 32'(e.rej));
  endtask

  function automatic res_t mk(input int ex, ey, ecx, ecy, ecw, ech, input bit erej);
    res_t r;
    r.x = ex[W-1:0]; r.y = ey[W-1:0]; r.cx = ecx[W-1:0]; r.cy = ecy[W-1:0];
    r.cw = ecw[W-1:0]; r.ch = ech[W-1:0]; r.rej = erej;
    return r;
  endfunction

  // Reference: numpad anchor, source interval clamp, then destination window intersection.
  function automatic res_t model(input req_t q);
    int mx, my, mcx, mcy, mcw, mch, lo, hi, col, row;
    bit rej;
    mx = q.x; my = q.y; mcx = q.cx; mcy = q.cy; mcw = q.cw; mch = q.ch; rej = 0;
    if (q.mi >= 4) rej = 1;
    else if (q.al >= 1 && q.al <= 9) begin
      col = (q.al - 1) % 3;
      row = (q.al - 1) / 3;
      if (col == 1) mx = mx - (mcw >>> 1);
      if (col == 2) mx = mx - mcw;
      if (row == 0) my = my - mch;
      if (row == 1) my = my - (mch >>> 1);
    end
    if (!rej) begin
      if (mcx >= q.tw) rej = 1;
      else if (mcx < 0) begin mx = mx - mcx; mcw = mcw + mcx; mcx = 0; end
    end
    if (!rej) begin
      if (mcy >= q.th) rej = 1;
      else if (mcy < 0) begin my = my - mcy; mch = mch + mcy; mcy = 0; end
    end
    if (!rej) begin
      if (mcw <= 0 || mch <= 0) rej = 1;
      else begin
        if (q.tw - mcx < mcw) mcw = q.tw - mcx;
        if (q.th - mcy < mch) mch = q.th - mcy;
      end
    end
    if (!rej) begin
      lo = (mx > q.l) ? mx : q.l;
      hi = (mx + mcw - 1 < q.r) ? mx + mcw - 1 : q.r;
      if (hi < lo) rej = 1;
      else begin
        mcx = mcx + ((q.mi % 2 == 1) ? (mx + mcw - 1 - hi) : (lo - mx));
        mcw = hi - lo + 1;
        mx  = lo;
      end
    end
    if (!rej) begin
      lo = (my > q.t) ? my : q.t;
      hi = (my + mch - 1 < q.b) ? my + mch - 1 : q.b;
      if (hi < lo) rej = 1;
      else begin
        mcy = mcy + ((q.mi >= 2) ? (my + mch - 1 - hi) : (lo - my));
        mch = hi - lo + 1;
        my  = lo;
      end
    end
    return mk(mx, my, mcx, mcy, rej ? 0 : mcw, rej ? 0 : mch, rej);
  endfunction

  function automatic req_t base_req();
    req_t q;
    q.tw = 64; q.th = 64; q.cx = 0; q.cy = 0; q.cw = 16; q.ch = 16;
    q.x = 10; q.y = 10; q.l = 0; q.t = 0; q.r = 99; q.b = 99; q.al = 7; q.mi = 0;
    return q;
  endfunction

  function automatic res_t capture();
    res_t r;
    r.x = o_x; r.y = o_y; r.cx = o_cx; r.cy = o_cy; r.cw = o_cw; r.ch = o_ch; r.rej = o_rej;
    return r;
  endfunction

  // Issue one request, check latency, optionally stall the response, then complete the handshake.
  task automatic run_req(input string tag, input req_t q, input int hold, output res_t o);
    int lat;
    res_t s;
    check_eq({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    tw = 16'(q.tw); th = 16'(q.th); cx = 16'(q.cx); cy = 16'(q.cy);
    cw = 16'(q.cw); ch = 16'(q.ch); x = 16'(q.x); y = 16'(q.y);
    lim_l = 16'(q.l); lim_t = 16'(q.t); lim_r = 16'(q.r); lim_b = 16'(q.b);
    align = 4'(q.al); mirror = 3'(q.mi);
    rsp_ready = (hold == 0);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, ".latency"}, 32'(lat), 32'd7);
    o = capture();
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      s = capture();
      check_eq({tag, ".hold_stable"}, 32'(s == o), 32'd1);
      check_eq({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      check_eq({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, ".after_hs_valid"}, 32'(rsp_valid), 32'd0);
  endtask

`ifdef PAINTERENGINE_GPU_CLIP_STATS_EN
  task automatic pulse_clear();
    stat_clear = 1'b1;
    @(posedge clk); #1;
    stat_clear = 1'b0;
  endtask
`endif

  initial begin
    req_t q;
    res_t o;
    int seen;
    #2;
    check_eq("rst.req_ready", 32'(req_ready), 32'd1);
    check_eq("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.reject", 32'(o_rej), 32'd0);
    check_eq("rst.outs", 32'(o_x | o_y | o_cx | o_cy | o_cw | o_ch), 32'd0);
    #10 resetn = 1'b1;
    @(posedge clk); #1;

    q = base_req();
    run_req("pass", q, 0, o);
    cmp_res("pass", o, mk(10, 10, 0, 0, 16, 16, 0));

    q = base_req(); q.al = 5; q.l = 4;
    run_req("center", q, 0, o);
    cmp_res("center", o, mk(4, 2, 2, 0, 14, 16, 0));

    q = base_req(); q.x = 90; q.y = 0; q.mi = 1;
    run_req("mirh", q, 0, o);
    cmp_res("mirh", o, mk(90, 0, 6, 0, 10, 16, 0));
    q.mi = 0;
    run_req("mir0", q, 0, o);
    cmp_res("mir0", o, mk(90, 0, 0, 0, 10, 16, 0));

    q = base_req(); q.cx = -4; q.x = 20;
    run_req("negcx", q, 0, o);
    cmp_res("negcx", o, mk(24, 10, 0, 0, 12, 16, 0));
    q.cx = 64;
    run_req("cxover", q, 0, o);
    cmp_res("cxover", o, mk(20, 10, 64, 0, 0, 0, 1));

`ifdef PAINTERENGINE_GPU_CLIP_STATS_EN
    pulse_clear();
`endif
    q = base_req(); q.x = 200;
    run_req("fullrej", q, 0, o);
    cmp_res("fullrej", o, mk(200, 10, 0, 0, 0, 0, 1));
`ifdef PAINTERENGINE_GPU_CLIP_STATS_EN
    check_eq("stat.accepted", 32'(stat_acc), 32'd1);
    check_eq("stat.rejected", 32'(stat_rej), 32'd1);
    pulse_clear();
    check_eq("stat.acc_clr", 32'(stat_acc), 32'd0);
    check_eq("stat.rej_clr", 32'(stat_rej), 32'd0);
`endif

    q = base_req();
    run_req("bp", q, 5, o);
    cmp_res("bp", o, mk(10, 10, 0, 0, 16, 16, 0));

    for (int n = 0; n < 40; n++) begin
      q.tw = $urandom_range(1, 80);   q.th = $urandom_range(1, 80);
      q.cx = $urandom_range(0, 130) - 40; q.cy = $urandom_range(0, 130) - 40;
      q.cw = $urandom_range(0, 65) - 5;   q.ch = $urandom_range(0, 65) - 5;
      q.x  = $urandom_range(0, 300) - 100; q.y = $urandom_range(0, 300) - 100;
      q.l  = $urandom_range(0, 70) - 20;   q.t = $urandom_range(0, 70) - 20;
      q.r  = q.l + $urandom_range(0, 150) - 5;
      q.b  = q.t + $urandom_range(0, 150) - 5;
      q.al = $urandom_range(0, 15);
      q.mi = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      run_req($sformatf("rnd%0d", n), q, (n % 7 == 3) ? 2 : 0, o);
      cmp_res($sformatf("rnd%0d", n), o, model(q));
    end

    // Reset while the request sits in LIM_X: nothing may come out.
    q = base_req();
    tw = 16'(q.tw); th = 16'(q.th); cw = 16'(q.cw); ch = 16'(q.ch); x = 16'(q.x); y = 16'(q.y);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check_eq("midrst.busy_before", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    check_eq("midrst.req_ready", 32'(req_ready), 32'd1);
    check_eq("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("midrst.busy", 32'(busy), 32'd0);
    check_eq("midrst.outs", 32'(o_x | o_y | o_cx | o_cy | o_cw | o_ch), 32'd0);
    check_eq("midrst.reject", 32'(o_rej), 32'd0);
    #2 resetn = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    check_eq("midrst.no_rsp", 32'(seen), 32'd0);

    q = base_req(); q.al = 5; q.l = 4;
    run_req("recover", q, 0, o);
    cmp_res("recover", o, model(q));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/painterengine_gpu_clip_stream.md
Name: painterengine_gpu_clip_stream

Overview:
- Parametrised successor to the GPU texture clip stage: resolves the alignment anchor, clips the source rectangle to texture bounds, then clips the destination to the limit window, with mirror-aware source offsets.
- Sits between the command decoder and the texture blitter; one request in, one response out, valid/ready on both sides.
- Adds proper signed arithmetic, negative-origin handling, explicit reject flag, backpressure and fixed latency.

Parameters:
- PARAM_COORD_WIDTH, 16, signed width of all coordinates and sizes, in and out.
- PARAM_STAT_WIDTH, 16, width of the statistics counters (optional feature only).

Ports:
- i_wire_clock  in  1  clock.
- i_wire_resetn  in  1  reset, asynchronous, active-low.
- i_wire_req_valid  in  1  request valid.
- o_wire_req_ready  out  1  high only in IDLE.
- i_wire_texture_width, i_wire_texture_height  in  W  texture size.
- i_wire_clip_x, i_wire_clip_y, i_wire_clip_width, i_wire_clip_height  in  W  source rectangle (cx, cy, cw, ch).
- i_wire_x, i_wire_y  in  W  destination anchor.
- i_wire_limit_left, i_wire_limit_top, i_wire_limit_right, i_wire_limit_bottom  in  W  inclusive limit window (L, T, R, B).
- i_wire_texture_align  in  4  numpad code 1..9.
- i_wire_texture_mirror_mode  in  3  0 none, 1 H, 2 V, 3 HV.
- o_wire_rsp_valid  out  1  response valid.
- i_wire_rsp_ready  in  1  response accept.
- o_wire_x, o_wire_y, o_wire_clipx, o_wire_clipy, o_wire_clipw, o_wire_cliph  out  W  result.
- o_wire_reject  out  1  nothing drawable.
- o_wire_busy  out  1  not IDLE.

Behaviour:
- W = PARAM_COORD_WIDTH. All inputs are two's-complement signed. Internal arithmetic is W+2 bits; results are truncated to W bits.
- Reset: state IDLE; o_wire_rsp_valid, o_wire_reject, o_wire_busy = 0; all W-bit outputs = 0; o_wire_req_ready = 1.
- A request is accepted when i_wire_req_valid && o_wire_req_ready. All inputs are registered on that edge.
- States and transitions: IDLE -> ALIGN -> TEX_X -> TEX_Y -> TEX_WH -> LIM_X -> LIM_Y -> RESP -> IDLE.
- Every state runs even after a reject, so o_wire_rsp_valid rises exactly 7 cycles after the accept edge.
- ALIGN:
  - hw = cw>>>1, hh = ch>>>1, using the input cw/ch.
  - x adjust: codes 8/5/2 subtract hw; codes 9/6/3 subtract cw.
  - y adjust: codes 4/5/6 subtract hh; codes 1/2/3 subtract ch.
  - Codes 7, 0 and 10..15 leave x/y unchanged.
- TEX_X:
  - If cx >= tw: reject.
  - Else if cx < 0: x -= cx; cw += cx; cx = 0.
- TEX_Y: same as TEX_X on cy, ch, y, th.
- TEX_WH:
  - If cw <= 0 or ch <= 0: reject.
  - If cx+cw > tw: cw = tw-cx.
  - If cy+ch > th: ch = th-cy.
- LIM_X:
  - l = max(0, L-x); r = max(0, x+cw-1-R).
  - If l+r >= cw: reject.
  - Else: cw -= l+r; x += l.
  - cx += r when mirror H or HV; otherwise cx += l.
- LIM_Y: same as LIM_X on T, B, y, ch, cy, using mirror V or HV.
- Mirror codes 4..7: reject.
- Reject handling: the sticky flag freezes x/y at their value when the reject fired; on response, clipw = cliph = 0, o_wire_reject = 1. clipx/clipy carry the frozen values.
- RESP:
  - Outputs are driven from registers and held stable while o_wire_rsp_valid && !i_wire_rsp_ready.
  - On the handshake edge: go to IDLE, rsp_valid drops. A new request can be accepted no earlier than the next cycle.
- o_wire_req_ready is 0 in every state other than IDLE; a request asserted while busy is not sampled.
- Reset asserted mid-operation: immediate return to the reset values; the in-flight request is dropped, with no response.

Optional Feature:
- Macro PAINTERENGINE_GPU_CLIP_STATS_EN.
- When defined, adds ports:
  - i_wire_stat_clear  in  1
  - o_wire_stat_accepted  out  PARAM_STAT_WIDTH
  - o_wire_stat_rejected  out  PARAM_STAT_WIDTH
- Counter behaviour:
  - accepted increments on each request handshake.
  - rejected increments on each response handshake with o_wire_reject = 1.
  - Both saturate at all-ones and reset to 0.
  - Synchronous clear has priority over increment.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Pass-through. Stimulus: tex 64x64, clip (0,0,16,16), x=10, y=10, align 7, mirror 0, limits (0,0,99,99). Response: x=10, y=10, clip (0,0,16,16), reject=0, rsp_valid on the 7th cycle after accept.
- Center align plus left limit. Stimulus: as above with align 5, L=4. Response: aligned (2,2), x=4, y=2, clipx=2, clipw=14, clipy=0, cliph=16.
- Mirror H right overflow. Stimulus: x=90, y=0, clip (0,0,16,16), mirror 1, R=99. Response: x=90, clipw=10, clipx=6; mirror 0 with the same stimulus gives clipx=0.
- Negative source origin. Stimulus: cx=-4, cw=16, x=20, tex 64. Response: x=24, clipx=0, clipw=12. With cx=64: reject=1, clipw=cliph=0.
- Full reject. Stimulus: x=200, w=16, R=99. Response: reject=1, x=200, clipw=cliph=0. With STATS_EN: accepted=1, rejected=1; a clear pulse zeroes both.
- Backpressure and reset. Stimulus: hold rsp_ready=0 for 5 cycles. Response: outputs stable, req_ready=0. Stimulus: resetn low during LIM_X. Response: all outputs 0, req_ready=1, no response emitted.
